// File: rtl/hart_intc_pkg.sv
// -----------------------------------------------------------------------------
// hart_intc_pkg
// Shared types and constants for the per-hart interrupt controller.
//   hart_intc_state_e : channel FSM state (IDLE / ASSERT / WAIT_CLR), 2 bits
//   MaxHarts          : upper bound on the number of hart channels
// Optional feature macro used by the design: HART_INTC_TIMEOUT_EN
// -----------------------------------------------------------------------------
package hart_intc_pkg;

   localparam int unsigned MaxHarts = 8;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ASSERT   = 2'd1,
      ST_WAIT_CLR = 2'd2
   } hart_intc_state_e;

endpackage

// File: rtl/hart_intc_chan.sv
// -----------------------------------------------------------------------------
// hart_intc_chan
// One hart's interrupt channel: raises the interrupt line on a request, waits
// for the hart's ack bit to rise and fall again, and queues one further request
// that arrives while the channel is busy.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   req_i        : request (one request per high cycle)
//   ack_i        : ack level from the hart's private ack register bit
//   irq_o        : registered interrupt line, high only in ASSERT
//   pending_o    : registered single-entry queued-request flag
//   timeout_o    : registered one-cycle pulse when ASSERT times out
//   state_o      : current FSM state (debug / busy reduction)
// Macro HART_INTC_TIMEOUT_EN: adds the ASSERT timeout counter; without it
// timeout_o is tied low and ASSERT is held until acked.
//
// Handshake: req_i is a level sampled every cycle; ack_i is a level that the
// hart raises to acknowledge and must drop before the next interrupt is raised.
// -----------------------------------------------------------------------------
module hart_intc_chan
   import hart_intc_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req_i,
   input  logic             ack_i,
   output logic             irq_o,
   output logic             pending_o,
   output logic             timeout_o,
   output hart_intc_state_e state_o
);

   hart_intc_state_e state_q, state_d;
   logic             pending_q, pending_d;
   logic             irq_q;

`ifdef HART_INTC_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LastCnt = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q;
   logic          timeout_q, timeout_d;
`endif

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
`ifdef HART_INTC_TIMEOUT_EN
      timeout_d = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (req_i) begin
               if (ack_i) begin
                  // Ack still high from the previous interrupt: hold the
                  // request until the hart clears its ack bit.
                  state_d   = ST_WAIT_CLR;
                  pending_d = 1'b1;
               end else begin
                  state_d = ST_ASSERT;
               end
            end
         end
         ST_ASSERT: begin
            pending_d = pending_q | req_i;
            if (ack_i) begin
               state_d = ST_WAIT_CLR;
            end
`ifdef HART_INTC_TIMEOUT_EN
            else if (cnt_q == LastCnt) begin
               state_d   = ST_IDLE;
               pending_d = 1'b0;
               timeout_d = 1'b1;
            end
`endif
         end
         ST_WAIT_CLR: begin
            pending_d = pending_q | req_i;
            if (!ack_i) begin
               if (pending_q || req_i) begin
                  // One queued request is consumed by re-entering ASSERT; a
                  // second one arriving in this same cycle stays queued.
                  state_d   = ST_ASSERT;
                  pending_d = pending_q & req_i;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d   = ST_IDLE;
            pending_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         pending_q <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         irq_q     <= (state_d == ST_ASSERT);
      end
   end

`ifdef HART_INTC_TIMEOUT_EN
   // Counter restarts on every entry to ASSERT and runs while there.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= timeout_d;
         if (state_q != ST_ASSERT && state_d == ST_ASSERT) begin
            cnt_q <= '0;
         end else if (state_q == ST_ASSERT) begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

   assign timeout_o = timeout_q;
`else
   assign timeout_o = 1'b0;
`endif

   assign irq_o     = irq_q;
   assign pending_o = pending_q;
   assign state_o   = state_q;

endmodule

// File: rtl/hart_intc_ctrl.sv
// -----------------------------------------------------------------------------
// hart_intc_ctrl
// Per-hart interrupt controller: NHARTS independent hart_intc_chan channels.
// Ports:
//   clk_i           : clock (rising edge)
//   rst_i           : synchronous active-high reset
//   irq_req_i       : per-hart request
//   hart_intc_ack_i : per-hart ack level
//   hart_irq_o      : per-hart interrupt line (registered)
//   pending_o       : per-hart queued-request flag (registered)
//   timeout_o       : per-hart timeout pulse (registered)
//   busy_o          : high while any channel is not IDLE (combinational)
// Macro HART_INTC_TIMEOUT_EN enables the per-channel ASSERT timeout.
// -----------------------------------------------------------------------------
module hart_intc_ctrl
   import hart_intc_pkg::*;
#(
   parameter int unsigned NHARTS         = 3,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [NHARTS-1:0] irq_req_i,
   input  logic [NHARTS-1:0] hart_intc_ack_i,
   output logic [NHARTS-1:0] hart_irq_o,
   output logic [NHARTS-1:0] pending_o,
   output logic [NHARTS-1:0] timeout_o,
   output logic              busy_o
);

   hart_intc_state_e chan_state [NHARTS];

   // Channels beyond MaxHarts are never built.
   for (genvar h = 0; h < MaxHarts; h++) begin : g_chan
      if (h < NHARTS) begin : g_inst
         hart_intc_chan #(
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
         ) u_chan (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .req_i     (irq_req_i[h]),
            .ack_i     (hart_intc_ack_i[h]),
            .irq_o     (hart_irq_o[h]),
            .pending_o (pending_o[h]),
            .timeout_o (timeout_o[h]),
            .state_o   (chan_state[h])
         );
      end
   end

   always_comb begin
      busy_o = 1'b0;
      for (int h = 0; h < NHARTS; h++) begin
         if (chan_state[h] != ST_IDLE) busy_o = 1'b1;
      end
   end

endmodule

// File: tb/tb_hart_intc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hart_intc_ctrl
// Directed bench for hart_intc_ctrl (NHARTS=3, TIMEOUT_CYCLES=16). Inputs are
// changed and outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_hart_intc_ctrl;

   localparam int unsigned NH  = 3;
   localparam int unsigned TMO = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic [NH-1:0] req;
   logic [NH-1:0] ack;
   logic [NH-1:0] irq;
   logic [NH-1:0] pend;
   logic [NH-1:0] tmo;
   logic          busy;

   int n_checks = 0;
   int n_pass   = 0;

   hart_intc_ctrl #(
      .NHARTS         (NH),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .irq_req_i       (req),
      .hart_intc_ack_i (ack),
      .hart_irq_o      (irq),
      .pending_o       (pend),
      .timeout_o       (tmo),
      .busy_o          (busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic chk_all(input string tag, input logic [NH-1:0] e_irq,
                          input logic [NH-1:0] e_pend, input logic [NH-1:0] e_tmo,
                          input logic e_busy);
      chk({tag, ".irq"},  32'(irq),  32'(e_irq));
      chk({tag, ".pend"}, 32'(pend), 32'(e_pend));
      chk({tag, ".tmo"},  32'(tmo),  32'(e_tmo));
      chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
   endtask

   initial begin
      rst = 1'b1; req = '0; ack = '0;
      step(); step();
      chk_all("reset", 3'b000, 3'b000, 3'b000, 1'b0);
      rst = 1'b0;
      step();
      chk_all("idle", 3'b000, 3'b000, 3'b000, 1'b0);

      // Basic: request, ack rise, ack fall.
      req = 3'b001; step();
      chk_all("basic.assert", 3'b001, 3'b000, 3'b000, 1'b1);
      req = 3'b000; step(); step(); step();
      chk("basic.hold", 32'(irq), 32'd1);
      ack = 3'b001; step();
      chk_all("basic.ack", 3'b000, 3'b000, 3'b000, 1'b1);
      ack = 3'b000; step();
      chk_all("basic.idle", 3'b000, 3'b000, 3'b000, 1'b0);

      // Queued request on hart 1.
      req = 3'b010; step();
      chk("queue.assert", 32'(irq), 32'd2);
      req = 3'b000; step();
      req = 3'b010; step();
      chk_all("queue.pend", 3'b010, 3'b010, 3'b000, 1'b1);
      req = 3'b000; ack = 3'b010; step();
      chk_all("queue.ack", 3'b000, 3'b010, 3'b000, 1'b1);
      step();
      chk_all("queue.ackhold", 3'b000, 3'b010, 3'b000, 1'b1);
      ack = 3'b000; step();
      chk_all("queue.reassert", 3'b010, 3'b000, 3'b000, 1'b1);
      ack = 3'b010; step();
      ack = 3'b000; step();
      chk_all("queue.idle", 3'b000, 3'b000, 3'b000, 1'b0);

      // Stale ack on hart 2.
      ack = 3'b100; req = 3'b100; step();
      chk_all("stale.wait", 3'b000, 3'b100, 3'b000, 1'b1);
      req = 3'b000; step(); step();
      chk("stale.noirq", 32'(irq), 32'd0);
      ack = 3'b000; step();
      chk_all("stale.assert", 3'b100, 3'b000, 3'b000, 1'b1);
      ack = 3'b100; step();
      ack = 3'b000; step();
      chk_all("stale.idle", 3'b000, 3'b000, 3'b000, 1'b0);

      // Simultaneous req+ack on hart 0 while hart 1 also asserted.
      req = 3'b011; step();
      chk("simul.both", 32'(irq), 32'd3);
      req = 3'b001; ack = 3'b001; step();
      chk_all("simul.reqack", 3'b010, 3'b001, 3'b000, 1'b1);
      req = 3'b000; ack = 3'b000; step();
      chk_all("simul.reassert", 3'b011, 3'b000, 3'b000, 1'b1);
      ack = 3'b011; step();
      ack = 3'b000; step();
      chk_all("simul.idle", 3'b000, 3'b000, 3'b000, 1'b0);

      // WAIT_CLR with queued request plus a new one while ack drops.
      req = 3'b001; step();
      ack = 3'b001; step();
      chk_all("wreq.wait", 3'b000, 3'b001, 3'b000, 1'b1);
      ack = 3'b000; req = 3'b001; step();
      chk_all("wreq.assert", 3'b001, 3'b001, 3'b000, 1'b1);
      req = 3'b000; ack = 3'b001; step();
      ack = 3'b000; step();
      chk_all("wreq.second", 3'b001, 3'b000, 3'b000, 1'b1);
      ack = 3'b001; step();
      ack = 3'b000; step();
      chk_all("wreq.idle", 3'b000, 3'b000, 3'b000, 1'b0);

      // Timeout behaviour on hart 0.
      req = 3'b001; step();               // cycle 1 of ASSERT
      req = 3'b000;
      for (int c = 2; c <= 16; c++) begin
         if (c == 5) req = 3'b001;
         step();
         req = 3'b000;
         chk("tmo.high", 32'(irq), 32'd1);
      end
      chk("tmo.pend", 32'(pend), 32'd1);
      step();
`ifdef HART_INTC_TIMEOUT_EN
      chk_all("tmo.fire", 3'b000, 3'b000, 3'b001, 1'b0);
      step();
      chk_all("tmo.pulse_end", 3'b000, 3'b000, 3'b000, 1'b0);
      // Ack in the timeout cycle wins.
      req = 3'b001; step();
      req = 3'b000;
      for (int c = 2; c <= 16; c++) step();
      chk("tmo2.high", 32'(irq), 32'd1);
      ack = 3'b001; step();
      chk_all("tmo2.ackwins", 3'b000, 3'b000, 3'b000, 1'b1);
      ack = 3'b000; step();
      chk_all("tmo2.idle", 3'b000, 3'b000, 3'b000, 1'b0);
`else
      chk_all("notmo.held", 3'b001, 3'b001, 3'b000, 1'b1);
      for (int c = 0; c < 20; c++) step();
      chk_all("notmo.still", 3'b001, 3'b001, 3'b000, 1'b1);
      ack = 3'b001; step();
      ack = 3'b000; step();
      ack = 3'b001; step();
      ack = 3'b000; step();
      chk_all("notmo.idle", 3'b000, 3'b000, 3'b000, 1'b0);
`endif

      // Reset with all channels asserted and pending.
      req = 3'b111; step();
      step();
      chk_all("rst.pre", 3'b111, 3'b111, 3'b000, 1'b1);
      rst = 1'b1; step();
      chk_all("rst.mid", 3'b000, 3'b000, 3'b000, 1'b0);
      rst = 1'b0; req = 3'b000; step();
      chk_all("rst.after", 3'b000, 3'b000, 3'b000, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
